// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller.
// Masks, latches, and fixed-priority arbitrates sources; runs one claim/EOI at a time.
module irq_ctrl #(
  parameter int WIDTH = 32,
  parameter int NIRQ  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [NIRQ-1:0]  irq_in,
  output logic             irq,
  output logic [4:0]       vector,
  output logic             in_service
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

  state_t state;
  state_t state_n;

  logic [NIRQ-1:0] enable;
  logic [NIRQ-1:0] mode;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] forced;
  logic [NIRQ-1:0] irq_q;
  logic            gie;

  logic [NIRQ-1:0] pending_n;
  logic [NIRQ-1:0] forced_n;
  logic [NIRQ-1:0] active;
  logic [NIRQ-1:0] edge_det;
  logic [NIRQ-1:0] force_set;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] claim_mask;
  logic [NIRQ-1:0] pend_edge;
  logic [NIRQ-1:0] wdata;
  logic [4:0]      winner;
  logic [4:0]      vfield;
  logic            any_active;
  logic            claim_ok;
  logic            valid;

  logic we;
  logic wr_en;
  logic wr_pend;
  logic wr_mode;
  logic wr_claim;
  logic wr_eoi;
  logic wr_ctrl;
  logic wr_force;

  assign we       = cs & wen;
  assign wr_en    = we & (addr == 4'd0);
  assign wr_pend  = we & (addr == 4'd1);
  assign wr_mode  = we & (addr == 4'd2);
  assign wr_claim = we & (addr == 4'd4);
  assign wr_eoi   = we & (addr == 4'd5);
  assign wr_ctrl  = we & (addr == 4'd6);
  assign wr_force = we & (addr == 4'd7);

  assign wdata = din[NIRQ-1:0];

  assign active     = pending & enable;
  assign any_active = |active;

  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (active[i]) winner = 5'(i);
    end
  end

  assign claim_ok = wr_claim & (state == REQ)
                  & gie & any_active;

  assign claim_mask = claim_ok ? (NIRQ'(1) << winner)
                               : '0;

  assign edge_det  = irq_in & ~irq_q;
  assign force_set = wr_force ? wdata : '0;
  assign w1c       = wr_pend ? wdata : '0;

  // Edge bits: set beats clear. Level bits: track the
  // input, plus a sticky latch that only FORCE can set.
  assign pend_edge = edge_det | force_set
                   | (pending & ~(w1c | claim_mask));

  assign forced_n = ~mode
                  & (force_set
                     | (forced & ~(w1c | claim_mask)));

  assign pending_n = (mode & pend_edge)
                   | (~mode & (irq_in | forced_n));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (gie && any_active) state_n = REQ;
      end
      REQ: begin
        if (!gie || !any_active) state_n = IDLE;
        else if (wr_claim) state_n = SERV;
      end
      SERV: begin
        if (wr_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable     <= '0;
      mode       <= '0;
      pending    <= '0;
      forced     <= '0;
      irq_q      <= '0;
      gie        <= 1'b0;
      state      <= IDLE;
      irq        <= 1'b0;
      vector     <= '0;
      in_service <= 1'b0;
    end else begin
      irq_q      <= irq_in;
      pending    <= pending_n;
      forced     <= forced_n;
      state      <= state_n;
      irq        <= (state_n == REQ);
      in_service <= (state_n == SERV);
      if (wr_en)    enable <= wdata;
      if (wr_mode)  mode   <= wdata;
      if (wr_ctrl)  gie    <= din[0];
      if (claim_ok) vector <= winner;
    end
  end

  assign valid  = (state == REQ) & any_active;
  assign vfield = (state == REQ) ? winner : vector;

  always_comb begin
    dout = '0;
    case (addr)
      4'd0: dout = WIDTH'(enable);
      4'd1: dout = WIDTH'(pending);
      4'd2: dout = WIDTH'(mode);
      4'd3: dout = WIDTH'(irq_in);
      4'd4: begin
        dout[WIDTH-1] = in_service;
        dout[WIDTH-2] = valid;
        dout[4:0]     = vfield;
      end
      4'd6: dout = WIDTH'(gie);
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl.
// Stimulus queues expectations; a negedge monitor drains and compares.
module tb_irq_ctrl;

  localparam int SEL_DOUT = 0;
  localparam int SEL_IRQ  = 1;
  localparam int SEL_INS  = 2;
  localparam int SEL_VEC  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        wen;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] irq_in;
  logic        irq;
  logic [4:0]  vector;
  logic        in_service;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int    vectors = 0;
  int    miscompares = 0;

  irq_ctrl #(.WIDTH(32), .NIRQ(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .wen        (wen),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .irq_in     (irq_in),
    .irq        (irq),
    .vector     (vector),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() != 0) begin
      item_t it;
      logic [31:0] obs;
      it = q.pop_front();
      case (it.sel)
        SEL_DOUT: obs = dout;
        SEL_IRQ:  obs = {31'd0, irq};
        SEL_INS:  obs = {31'd0, in_service};
        default:  obs = {27'd0, vector};
      endcase
      vectors++;
      if (obs !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %h want %h",
                 it.name, obs, it.exp);
      end
    end
  end

  task automatic push(input int sel,
                      input logic [31:0] e,
                      input string n);
    item_t it;
    it.sel  = sel;
    it.exp  = e;
    it.name = n;
    q.push_back(it);
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [31:0] e,
                    input string n);
    addr = a;
    push(SEL_DOUT, e, n);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [31:0] d);
    cs   = 1'b1;
    wen  = 1'b1;
    addr = a;
    din  = d;
    tick();
    cs   = 1'b0;
    wen  = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    cs     = 1'b0;
    wen    = 1'b0;
    addr   = '0;
    din    = '0;
    irq_in = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // reset state
    push(SEL_IRQ, 0, "rst_irq");
    push(SEL_INS, 0, "rst_ins");
    push(SEL_VEC, 0, "rst_vec");
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 32'h0, $sformatf("rst_reg%0d", a));
      step();
    end

    // single edge source
    wr(4'd0, 32'h2);
    wr(4'd2, 32'h2);
    wr(4'd6, 32'h1);
    irq_in = 32'h2;
    tick();
    irq_in = '0;
    push(SEL_IRQ, 0, "e1_irq_early");
    rd(4'd1, 32'h2, "e1_pending");
    step();
    tick();
    push(SEL_IRQ, 1, "e1_irq");
    rd(4'd4, 32'h4000_0001, "e1_claim_rd");
    step();
    wr(4'd4, 32'h0);
    push(SEL_IRQ, 0, "e1_irq_claimed");
    push(SEL_INS, 1, "e1_ins");
    push(SEL_VEC, 1, "e1_vec");
    rd(4'd4, 32'h8000_0001, "e1_claim_serv");
    step();
    rd(4'd1, 32'h0, "e1_pending_clr");
    step();
    wr(4'd5, 32'h0);
    push(SEL_INS, 0, "e1_eoi_ins");
    push(SEL_IRQ, 0, "e1_eoi_irq");
    step();
    push(SEL_IRQ, 0, "e1_irq_quiet");
    step();

    // two simultaneous edges, priority
    wr(4'd0, 32'h28);
    wr(4'd2, 32'h28);
    irq_in = 32'h28;
    tick();
    irq_in = '0;
    tick();
    push(SEL_IRQ, 1, "p_irq");
    rd(4'd4, 32'h4000_0003, "p_claim_rd3");
    step();
    wr(4'd4, 32'h0);
    push(SEL_VEC, 3, "p_vec3");
    push(SEL_INS, 1, "p_ins3");
    rd(4'd1, 32'h20, "p_pending5");
    step();
    wr(4'd5, 32'h0);
    push(SEL_IRQ, 0, "p_irq_eoi");
    push(SEL_INS, 0, "p_ins_eoi");
    tick();
    push(SEL_IRQ, 1, "p_irq_re");
    rd(4'd4, 32'h4000_0005, "p_claim_rd5");
    step();
    wr(4'd4, 32'h0);
    push(SEL_VEC, 5, "p_vec5");
    rd(4'd1, 32'h0, "p_pending_none");
    step();
    wr(4'd5, 32'h0);
    push(SEL_INS, 0, "p_ins_end");
    tick();
    push(SEL_IRQ, 0, "p_irq_idle");
    step();

    // level source held high
    wr(4'd0, 32'h1);
    wr(4'd2, 32'h0);
    irq_in = 32'h1;
    tick();
    tick();
    push(SEL_IRQ, 1, "l_irq");
    rd(4'd4, 32'h4000_0000, "l_claim_rd");
    step();
    wr(4'd4, 32'h0);
    push(SEL_INS, 1, "l_ins");
    push(SEL_VEC, 0, "l_vec");
    rd(4'd1, 32'h1, "l_pending_held");
    step();
    wr(4'd1, 32'h1);
    rd(4'd1, 32'h1, "l_w1c_noeffect");
    step();
    rd(4'd3, 32'h1, "l_raw");
    step();
    wr(4'd5, 32'h0);
    push(SEL_INS, 0, "l_eoi_ins");
    push(SEL_IRQ, 0, "l_eoi_irq");
    step();
    tick();
    push(SEL_IRQ, 1, "l_irq_re");

    // mask while requesting
    wr(4'd0, 32'h0);
    tick();
    push(SEL_IRQ, 0, "m_irq_drop");
    rd(4'd4, 32'h0, "m_claim_idle");
    step();
    wr(4'd4, 32'h0);
    push(SEL_INS, 0, "m_claim_ignored");
    rd(4'd4, 32'h0, "m_claim_rd_after");
    step();
    irq_in = '0;

    // force, then reset during service
    wr(4'd0, 32'h80);
    wr(4'd7, 32'h80);
    tick();
    push(SEL_IRQ, 1, "f_irq");
    rd(4'd4, 32'h4000_0007, "f_claim_rd");
    step();
    wr(4'd4, 32'h0);
    push(SEL_VEC, 7, "f_vec");
    push(SEL_INS, 1, "f_ins");
    rd(4'd1, 32'h0, "f_pending_clr");
    step();
    reset = 1'b0;
    #1;
    push(SEL_INS, 0, "r_ins");
    push(SEL_VEC, 0, "r_vec");
    push(SEL_IRQ, 0, "r_irq");
    rd(4'd0, 32'h0, "r_enable");
    step();
    rd(4'd6, 32'h0, "r_ctrl");
    step();
    rd(4'd2, 32'h0, "r_mode");
    step();
    reset = 1'b1;
    rd(4'd0, 32'h0, "r_enable_after");
    step();

    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d left want 0", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller; a bus slave on the CPU memory bus, selected by a chip-select from the address decoder.
- Collects up to NIRQ peripheral interrupt requests (timer, uart, clock, ...), for example the computer's irqs vector.
- Masks and latches the requests, and arbitrates them by fixed priority: lowest index wins.
- Sequences a single request through claim and end-of-interrupt toward the CPU, so at most one interrupt is in service at a time.

Parameters:
WIDTH, 32, bus data width.
NIRQ, 32, number of interrupt sources (1..32); source bits at index NIRQ and above read 0 and ignore writes.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
cs  in  1  chip select from address decoder
wen  in  1  bus write enable; a write occurs on the clk edge when cs&wen
addr  in  4  register select (bus_address[3:0])
din  in  WIDTH  bus write data
dout  out  WIDTH  register read data (combinational from addr; 0 for unused addresses)
irq_in  in  NIRQ  synchronous interrupt requests, active-high
irq  out  1  interrupt request to CPU (registered)
vector  out  5  index of the interrupt in service
in_service  out  1  an interrupt is claimed and not yet ended

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-low.
- Reset values: ENABLE=0, MODE=0, PENDING=0, GIE=0, irq_q=0, state=IDLE, irq=0, vector=0, in_service=0.
- Register map (addr):
  - 0 ENABLE RW.
  - 1 PENDING: read; write-1-to-clear, edge-mode bits only.
  - 2 MODE RW: 1=edge, 0=level.
  - 3 RAW RO: irq_in.
  - 4 CLAIM: read returns {in_service, valid, 25'b0, vector}; write of any value = claim.
  - 5 EOI: write of any value ends service.
  - 6 CTRL RW: bit0 = GIE.
  - 7 FORCE: write-1 sets PENDING bits, any mode.
  - 8..15 unused: read 0, writes ignored.
- irq_q: one-cycle registered copy of irq_in. Edge detect is irq_in & ~irq_q.
- Edge-mode pending bit:
  - Set by an edge or by FORCE.
  - Cleared by W1C or by claim.
  - Set wins over clear in the same cycle.
- Level-mode pending bit:
  - Next value = irq_in | forced_latch.
  - W1C clears only forced_latch; claim also clears forced_latch.
- active = PENDING & ENABLE; winner = lowest set index of active.
- FSM states IDLE, REQ, SERV:
  - IDLE: if GIE & |active, go to REQ next cycle; irq=1 from the REQ cycle onward.
  - REQ:
    - If GIE=0 or active==0 (masked or cleared meanwhile), return to IDLE with irq=0.
    - If a claim write occurs: latch vector=winner (evaluated in the write cycle), clear that pending bit as per mode rules, set in_service=1, irq=0, go to SERV.
  - SERV:
    - New requests keep latching into PENDING; irq stays 0 (no nesting).
    - EOI write sets in_service=0 and goes to IDLE.
    - If active is still non-zero, irq reasserts one cycle later.
  - A claim write outside REQ is ignored.
  - An EOI write outside SERV is ignored.
- CLAIM read: valid=1 when state=REQ and active!=0; vector field shows the current winner in REQ and the latched vector in SERV.
- Reset asserted mid-operation returns immediately to the reset values, including dropping service.
- Level-mode source held high through EOI: re-requests after EOI.
- Fully synchronous except reset; no combinational path from irq_in to irq.

Test Plan:
- Reset low, then high; read all registers -> all 0, irq=0.
- ENABLE=0x2, MODE=0x2, GIE=1; pulse irq_in[1] for 1 cycle -> irq=1 two cycles later. CLAIM read = 0x40000001. Claim write -> irq=0, in_service=1, vector=1, PENDING=0. EOI -> in_service=0, irq stays 0.
- Edge pulses on bits 3 and 5 in the same cycle, both enabled -> claim gives vector 3. After EOI irq reasserts; second claim gives vector 5.
- Level mode bit 0, irq_in[0] held high through claim and EOI -> PENDING[0] stays 1; irq reasserts one cycle after EOI. W1C to PENDING[0] has no effect.
- In REQ, write ENABLE=0 -> irq drops to 0 next cycle, state IDLE. A claim write afterward leaves in_service=0.
- FORCE write 0x80 with GIE=1, ENABLE=0x80 -> irq=1, claim gives vector 7. Assert reset during SERV -> in_service=0, vector=0, registers cleared.
